timer_scheduler: RTL and testbench

Shared timebase and timeout scheduler for the vending machine controller. It derives one prescaled tick from clk_in and uses it to run NCH independent countdown channels, such as the coin-insert timeout, the dispense motor on-time and the display blink period. Requesters start or cancel a channel with single-cycle pulses and receive a one-cycle expiry pulse. It replaces per-function free-running dividers with one scheduled resource.

---
 rtl/timer_scheduler_pkg.sv | 23 ++
 rtl/timer_scheduler_tick_gen.sv | 35 +++
 rtl/timer_scheduler.sv | 100 ++++++++++
 tb/tb_timer_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_scheduler_pkg.sv
// Shared defaults, channel state encoding and the width helper for the timer scheduler.
package timer_scheduler_pkg;

  localparam int unsigned DEF_DIV = 100;
  localparam int          DEF_NCH = 4;
  localparam int          DEF_CW  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // ceil(log2(n)) with a floor of 1 so a single-channel build still has a select bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/timer_scheduler_tick_gen.sv
// Prescaler: counts enabled clk_in cycles 0..DIV-1 and emits a registered one-cycle tick on wrap.
// Tick is high in the cycle after the count==DIV-1 edge; enable low holds the count and forces tick low.
module tick_gen
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] cnt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 32'd1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// NCH independent tick-based countdown channels sharing one prescaler; start/cancel take effect on the sampling edge.
// expired/any_expired are registered one-cycle pulses; rd_val is a combinational mux of channel counts.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV,
  parameter int          NCH = DEF_NCH,
  parameter int          CW  = DEF_CW,
  localparam int         SW  = clog2_min1(NCH)
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCH-1:0]      start,
  input  logic [NCH-1:0]      cancel,
  input  logic [NCH*CW-1:0]   load_val,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      expired,
  output logic                any_expired,
  output logic                tick,
  input  logic [SW-1:0]       rd_sel,
  output logic [CW-1:0]       rd_val
);

  logic [NCH-1:0]    exp_nxt;
  logic [NCH*CW-1:0] cnt_flat;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, ld;
    logic          exp_q, exp_d;

    assign ld = load_val[i*CW +: CW];

    // Priority: cancel, then start (load or immediate expiry), then tick-driven countdown.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = 1'b0;
      if (cancel[i]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (start[i]) begin
        if (ld != '0) begin
          state_d = ST_RUN;
          cnt_d   = ld;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          exp_d   = 1'b1;
        end
      end else if (state_q == ST_RUN && tick && enable) begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          exp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        exp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        exp_q   <= exp_d;
      end
    end

    assign busy[i]               = (state_q == ST_RUN);
    assign expired[i]            = exp_q;
    assign exp_nxt[i]            = exp_d;
    assign cnt_flat[i*CW +: CW]  = cnt_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) any_expired <= 1'b0;
    else       any_expired <= |exp_nxt;
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NCH; k++) begin
      if (SW'(k) == rd_sel) rd_val = cnt_flat[k*CW +: CW];
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler (DIV=4, NCH=4, CW=8): directed vector table, corner sequences, random run vs reference model.
module tb_timer_scheduler;

  localparam int DIV = 4;
  localparam int NCH = 4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  start, cancel;
  logic [31:0] load_val;
  logic [1:0]  rd_sel;
  logic [3:0]  busy, expired;
  logic        any_expired, tick;
  logic [7:0]  rd_val;

  always #5 clk_in = ~clk_in;

  timer_scheduler #(.DIV(DIV), .NCH(NCH), .CW(8)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .cancel      (cancel),
    .load_val    (load_val),
    .busy        (busy),
    .expired     (expired),
    .any_expired (any_expired),
    .tick        (tick),
    .rd_sel      (rd_sel),
    .rd_val      (rd_val)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: remaining ticks per channel (busy iff >0) and a count of enabled cycles.
  int       m_cnt [NCH];
  int       ecnt;
  bit       m_tick, m_any;
  bit [3:0] m_exp;
  bit [3:0] exp_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout, expected event within bound", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    ecnt = 0; m_tick = 0; m_any = 0; m_exp = '0;
  endtask

  task automatic model_edge();
    bit       nt;
    bit [3:0] ne;
    int       lv;
    nt = 0;
    ne = '0;
    if (enable) begin
      ecnt++;
      nt = (ecnt % DIV == 0);
    end
    for (int i = 0; i < NCH; i++) begin
      lv = int'((load_val >> (8 * i)) & 32'hFF);
      if (cancel[i]) m_cnt[i] = 0;
      else if (start[i]) begin
        m_cnt[i] = lv;
        if (lv == 0) ne[i] = 1;
      end else if (m_cnt[i] > 0 && m_tick && enable) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) ne[i] = 1;
      end
    end
    m_exp = ne; m_any = |ne; m_tick = nt;
  endtask

  // One clock: model follows the edge, outputs are checked 1 ns later, pulses are dropped.
  task automatic step();
    bit [3:0] mb;
    @(posedge clk_in);
    model_edge();
    #1;
    for (int i = 0; i < NCH; i++) mb[i] = (m_cnt[i] > 0);
    chk("busy", busy, mb);
    chk("expired", expired, m_exp);
    chk("any_expired", any_expired, m_any);
    chk("tick", tick, m_tick);
    chk("rd_val", rd_val, m_cnt[rd_sel]);
    exp_seen |= expired;
    start = '0;
    cancel = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_expired", expired, 0);
    chk("rst_any", any_expired, 0);
    chk("rst_tick", tick, 0);
    chk("rst_rd_val", rd_val, 0);
    model_reset();
    start = '0; cancel = '0; enable = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  st;
    logic [31:0] lv;
    logic [1:0]  sel;
    logic [3:0]  e_busy;
    logic [3:0]  e_exp;
    logic        e_any;
    logic        e_tick;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [16];
  int   n0, n1, nt;
  bit   paused;

  // Runs ch0 with load 3 from a tick-aligned start; optionally pauses 10 cycles at count 2.
  task automatic run_len(input bit pause, output int n);
    int guard;
    guard = 0;
    while (!tick && guard < 20) begin step(); guard++; end
    if (!tick) timeout("align_tick");
    start = 4'h1; load_val = 32'h3; rd_sel = 2'd0;
    step();
    n = 1;
    paused = 0;
    guard = 0;
    while (!expired[0] && guard < 200) begin
      if (pause && !paused && rd_val == 8'd2) begin
        paused = 1;
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
          step(); n++;
          chk("pause_tick", tick, 0);
          chk("pause_rd_val", rd_val, 2);
        end
        enable = 1'b1;
      end else begin
        step(); n++;
      end
      guard++;
    end
    if (!expired[0]) timeout("pause_expiry");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = '0; cancel = '0; load_val = '0; rd_sel = '0;
    exp_seen = '0;
    model_reset();

    //            start lv            sel   busy  exp   any tick rd
    tbl[0]  = '{4'h0, 32'h0, 2'd0, 4'h0, 4'h0, 0, 0, 8'd0};
    tbl[1]  = '{4'h1, 32'h3, 2'd0, 4'h1, 4'h0, 0, 0, 8'd3};
    tbl[2]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd3};
    tbl[3]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 1, 8'd3};
    tbl[4]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd2};
    tbl[5]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd2};
    tbl[6]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd2};
    tbl[7]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 1, 8'd2};
    tbl[8]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd1};
    tbl[9]  = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd1};
    tbl[10] = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 0, 8'd1};
    tbl[11] = '{4'h0, 32'h0, 2'd0, 4'h1, 4'h0, 0, 1, 8'd1};
    tbl[12] = '{4'h0, 32'h0, 2'd0, 4'h0, 4'h1, 1, 0, 8'd0};
    tbl[13] = '{4'h0, 32'h0, 2'd0, 4'h0, 4'h0, 0, 0, 8'd0};
    tbl[14] = '{4'h4, 32'h0, 2'd2, 4'h0, 4'h4, 1, 0, 8'd0};
    tbl[15] = '{4'h0, 32'h0, 2'd0, 4'h0, 4'h0, 0, 1, 8'd0};

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_tick", tick, 0);
    chk("reset_rd_val", rd_val, 0);
    reset = 1'b0;

    // Row r drives cycle r and checks cycle r+1 after release.
    for (int r = 0; r < 16; r++) begin
      start = tbl[r].st; load_val = tbl[r].lv; rd_sel = tbl[r].sel;
      step();
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_exp", r), expired, tbl[r].e_exp);
      chk($sformatf("tbl%0d_any", r), any_expired, tbl[r].e_any);
      chk($sformatf("tbl%0d_tick", r), tick, tbl[r].e_tick);
      chk($sformatf("tbl%0d_rd", r), rd_val, tbl[r].e_rd);
    end

    // Cancel on the third tick, then cancel+start together.
    exp_seen = '0;
    start = 4'h2; load_val = 32'h0500; rd_sel = 2'd1;
    step();
    nt = 0;
    for (int g = 0; g < 60 && nt < 3; g++) begin
      if (tick) nt++;
      if (nt < 3) step();
    end
    if (nt < 3) timeout("third_tick");
    cancel = 4'h2;
    step();
    chk("cancel_busy", busy[1], 0);
    repeat (8) step();
    start = 4'h2; cancel = 4'h2; load_val = 32'h0500;
    step();
    chk("cancel_start_busy", busy[1], 0);
    repeat (6) step();
    chk("cancel_no_expiry", exp_seen[1], 0);

    // Zero load and retrigger.
    exp_seen = '0;
    start = 4'h4; load_val = 32'h0;
    step();
    chk("zero_load_exp", expired[2], 1);
    step();
    chk("zero_load_single", expired[2], 0);
    chk("zero_load_busy_seen", busy[2], 0);
    start = 4'h8; load_val = 32'h0200_0000; rd_sel = 2'd3;
    step();
    for (int g = 0; g < 10 && !tick; g++) step();
    if (!tick) timeout("retrig_tick");
    step();
    chk("retrig_pre", rd_val, 1);
    start = 4'h8; load_val = 32'h0400_0000;
    step();
    chk("retrig_rd_val", rd_val, 4);
    nt = 0;
    begin
      int g;
      for (g = 0; g < 100 && !expired[3]; g++) begin
        if (tick) nt++;
        step();
      end
      if (!expired[3]) timeout("retrig_expiry");
    end
    chk("retrig_ticks", nt, 4);

    // Simultaneous expiry on two channels.
    start = 4'h3; load_val = 32'h0202;
    step();
    for (int g = 0; g < 40 && !any_expired; g++) step();
    if (!any_expired) timeout("concurrent_expiry");
    chk("concurrent_bits", expired, 4'h3);
    step();
    chk("concurrent_any_once", any_expired, 0);

    // Pause adds exactly the paused cycles.
    run_len(1'b0, n0);
    run_len(1'b1, n1);
    chk("pause_delay", n1, n0 + 10);

    // Reset mid-run.
    start = 4'hF; load_val = 32'h0505_0505;
    repeat (3) step();
    chk("pre_reset_busy", busy, 4'hF);
    do_reset();
    exp_seen = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("post_reset_tick_c%0d", c), tick, (c % 4 == 0));
    end
    chk("post_reset_no_expiry", exp_seen, 0);

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      enable = ($urandom_range(9) != 0);
      for (int i = 0; i < NCH; i++) begin
        start[i]  = ($urandom_range(5) == 0);
        cancel[i] = ($urandom_range(11) == 0);
        load_val[8*i +: 8] = 8'($urandom_range(5));
      end
      rd_sel = 2'($urandom_range(3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
